mult8_rev_seq: RTL

- Sequencing controller for the 8x8 reversible multiplier core.
- Accepts forward (multiply) and backward (un-compute) requests over one valid/ready channel.
- Drives the core's `dir` and operand buses; keeps a LIFO history of forward outputs (product and pass-through A) so backward steps replay them in reverse order.
- Sits between the pipeline stage scheduler and the multiplier instance.

---
 rtl/mult8_rev_seq.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/mult8_rev_seq.sv
// Sequencing controller for the 8x8 reversible multiplier core: forward/backward requests with a LIFO history.
// Optional MULT8_REV_CHECK_EN adds a shadow operand stack and a recovery-mismatch flag on backward responses.
module mult8_rev_seq #(
    parameter  int DEPTH = 8,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_dir,
    input  logic [7:0]    req_a,
    input  logic [7:0]    req_b,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_dir,
    output logic          rsp_err,
    output logic          rsp_mismatch,
    output logic [15:0]   rsp_p,
    output logic [7:0]    rsp_a,
    output logic [7:0]    rsp_b,
    output logic          m_dir,
    output logic [7:0]    m_f_a,
    output logic [7:0]    m_f_b,
    input  logic [15:0]   m_f_p,
    input  logic [7:0]    m_f_a_b,
    output logic [15:0]   m_r_p,
    output logic [7:0]    m_r_a_b,
    input  logic [7:0]    m_r_a,
    input  logic [7:0]    m_r_b,
    output logic [CW-1:0] occ,
    output logic          full,
    output logic          empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]    state;
    logic          dir_q;
    logic [7:0]    a_q;
    logic [7:0]    b_q;
    logic [23:0]   stack [DEPTH];
    logic [23:0]   top;
    logic [PW-1:0] top_idx;
    logic [PW-1:0] push_idx;
    logic          exec_fwd;
    logic          exec_bwd;
    logic          illegal;

    assign full      = (occ == DEPTH_C);
    assign empty     = (occ == '0);
    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign illegal   = req_dir ? empty : full;

    assign top_idx  = PW'(occ - CW'(1));
    assign push_idx = PW'(occ);
    assign top      = stack[top_idx];

    // Core ports are driven only while EXEC, so the core never sees both directions at once.
    assign exec_fwd = (state == EXEC) && !dir_q;
    assign exec_bwd = (state == EXEC) && dir_q;
    assign m_dir    = exec_bwd;
    assign m_f_a    = exec_fwd ? a_q : '0;
    assign m_f_b    = exec_fwd ? b_q : '0;
    assign m_r_p    = exec_bwd ? top[23:8] : '0;
    assign m_r_a_b  = exec_bwd ? top[7:0]  : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            dir_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            occ     <= '0;
            rsp_dir <= 1'b0;
            rsp_err <= 1'b0;
            rsp_p   <= '0;
            rsp_a   <= '0;
            rsp_b   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stack[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (illegal) begin
                            state   <= RESP;
                            rsp_dir <= req_dir;
                            rsp_err <= 1'b1;
                            rsp_p   <= '0;
                            rsp_a   <= '0;
                            rsp_b   <= '0;
                        end else begin
                            state <= EXEC;
                            dir_q <= req_dir;
                            a_q   <= req_a;
                            b_q   <= req_b;
                        end
                    end
                end
                EXEC: begin
                    state   <= RESP;
                    rsp_dir <= dir_q;
                    rsp_err <= 1'b0;
                    if (!dir_q) begin
                        rsp_p           <= m_f_p;
                        rsp_a           <= m_f_a_b;
                        rsp_b           <= '0;
                        stack[push_idx] <= {m_f_p, m_f_a_b};
                        occ             <= occ + CW'(1);
                    end else begin
                        rsp_p <= top[23:8];
                        rsp_a <= m_r_a;
                        rsp_b <= m_r_b;
                        occ   <= occ - CW'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MULT8_REV_CHECK_EN
    logic [15:0] shadow [DEPTH];
    logic [15:0] shadow_top;

    assign shadow_top = shadow[top_idx];

    // A zero A makes B unrecoverable, so B is only checked when the original A was nonzero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_mismatch <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                shadow[i] <= '0;
            end
        end else if (state == IDLE && req_valid && illegal) begin
            rsp_mismatch <= 1'b0;
        end else if (state == EXEC) begin
            if (!dir_q) begin
                shadow[push_idx] <= {a_q, b_q};
                rsp_mismatch     <= 1'b0;
            end else begin
                rsp_mismatch <= (shadow_top[15:8] != m_r_a) ||
                                ((shadow_top[15:8] != 8'h00) && (shadow_top[7:0] != m_r_b));
            end
        end
    end
`else
    assign rsp_mismatch = 1'b0;
`endif

endmodule
